// File: rtl/req_priority_encoder.sv
// Registered priority encoder: sticky pending vector drained lowest-index-first over valid/ready.
// Latency: a req_in pulse appears on idx_out one edge later when the output stage is free.
// Backpressure: with idx_valid & ~idx_ready the output holds and new events accumulate in pending.
// Optional multi-hot checker enabled by defining REQ_ONEHOT_CHK_EN.
module req_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             clear,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [N-1:0]     pending,
    output logic             pend_any,
    output logic             onehot_err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_any_q;

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] sel;
    logic             hit;
    logic             load;
    logic [N-1:0]     sel_mask;

    assign cand = pending_q | req_in;
    assign load = (state_q == IDLE) | idx_ready;

    // Descending scan: the last assignment wins, so the lowest set bit is selected.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

    assign sel_mask = {{(N-1){1'b0}}, 1'b1} << sel;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        if (clear) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (load) begin
                        if (hit) begin
                            state_d   = HOLD;
                            idx_d     = sel;
                            pending_d = cand & ~sel_mask;
                        end else begin
                            state_d   = IDLE;
                            pending_d = '0;
                        end
                    end else begin
                        pending_d = cand;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            idx_q      <= '0;
            pend_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            pend_any_q <= |pending_d;
        end
    end

    assign idx_out   = idx_q;
    assign idx_valid = (state_q == HOLD);
    assign pending   = pending_q;
    assign pend_any  = pend_any_q;

`ifdef REQ_ONEHOT_CHK_EN
    logic err_q, err_d;
    logic multi_hot;

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign multi_hot = |(req_in & (req_in - {{(N-1){1'b0}}, 1'b1}));

    always_comb begin
        err_d = err_q | multi_hot;
        if (clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign onehot_err = err_q;
`else
    assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed and randomized bench for req_priority_encoder against an event-set reference model.
module tb_req_priority_encoder;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_in;
    logic             clear;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             idx_ready;
    logic [N-1:0]     pending;
    logic             pend_any;
    logic             onehot_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: a set of outstanding events plus the one being presented.
    bit pend_set[N];
    bit m_valid;
    int m_idx;
    bit m_err;

    req_priority_encoder #(.N(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .clear      (clear),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .pending    (pending),
        .pend_any   (pend_any),
        .onehot_err (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) pend_set[i] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic clr, input logic rdy);
        int nbits;
        int first;
        if (clr) begin
            for (int i = 0; i < N; i++) pend_set[i] = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            return;
        end
        nbits = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                nbits++;
                pend_set[i] = 1'b1;
            end
        end
`ifdef REQ_ONEHOT_CHK_EN
        if (nbits >= 2) m_err = 1'b1;
`endif
        if (!m_valid || rdy) begin
            first = -1;
            for (int i = 0; i < N; i++) begin
                if (pend_set[i] && first < 0) first = i;
            end
            if (first >= 0) begin
                m_valid = 1'b1;
                m_idx   = first;
                pend_set[first] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = pend_set[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] mp;
        mp = model_pending();
        chk({tag, ".idx_valid"},  32'(idx_valid),  32'(m_valid));
        chk({tag, ".idx_out"},    32'(idx_out),    32'(m_idx));
        chk({tag, ".pending"},    32'(pending),    32'(mp));
        chk({tag, ".pend_any"},   32'(pend_any),   32'(|mp));
        chk({tag, ".onehot_err"}, 32'(onehot_err), 32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req_in, clear, idx_ready);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");
    endtask

    initial begin
        rst_n     = 1'b1;
        req_in    = '0;
        clear     = 1'b0;
        idx_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single event
        idx_ready = 1'b1;
        req_in = 8'h04; step("single_t1");
        chk("single.idx_out_is_2", 32'(idx_out), 32'd2);
        req_in = 8'h00; step("single_t2");
        chk("single.drained", 32'(idx_valid), 32'd0);

        // Drain order 1,4,7
        req_in = 8'h92; step("drain_1");
        chk("drain.first_idx", 32'(idx_out), 32'd1);
        req_in = 8'h00; step("drain_4");
        chk("drain.second_idx", 32'(idx_out), 32'd4);
        step("drain_7");
        chk("drain.third_idx", 32'(idx_out), 32'd7);
        step("drain_empty");

        // Backpressure and coalescing
        idx_ready = 1'b0;
        req_in = 8'h01; step("bp_load0");
        req_in = 8'h80; step("bp_80a");
        step("bp_80b");
        chk("bp.coalesced", 32'(pending), 32'h80);
        req_in = 8'h01; step("bp_81");
        chk("bp.same_line_new", 32'(pending), 32'h81);
        req_in = 8'h00;
        idx_ready = 1'b1; step("bp_out0");
        step("bp_out7");
        chk("bp.out7", 32'(idx_out), 32'd7);
        step("bp_empty");

        // Clear beats req_in and the handshake
        idx_ready = 1'b0;
        req_in = 8'h01; step("clr_setup0");
        req_in = 8'h30; step("clr_setup30");
        chk("clr.setup_pending", 32'(pending), 32'h30);
        req_in = 8'h0F; clear = 1'b1; step("clr_apply");
        chk("clr.valid_low", 32'(idx_valid), 32'd0);
        clear = 1'b0; req_in = 8'h00; step("clr_after");

        // Async reset in the middle of a drain
        idx_ready = 1'b1;
        req_in = 8'hFF; step("rst_ff");
        req_in = 8'h00; step("rst_acc1");
        step("rst_acc2");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid");
        chk("rst_mid.pending_zero", 32'(pending), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_release");

        // Multi-hot request: both bits still delivered; flag sticky until clear
        req_in = 8'h03; step("mh_load");
        chk("mh.idx0", 32'(idx_out), 32'd0);
        req_in = 8'h00; step("mh_idx1");
        chk("mh.idx1", 32'(idx_out), 32'd1);
        step("mh_idle");
        step("mh_sticky");
        clear = 1'b1; step("mh_clear");
        clear = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            req_in    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            idx_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 29) == 0);
            step("rand");
        end
        clear  = 1'b0;
        req_in = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
